cardinal_nic: RTL
=================

# cardinal_nic

Network interface controller between a processing element (PE) and one local port of the `gold_mesh` cardinal router. Each node has one NIC.
- It buffers flits the PE writes through a 2-bit register address map and injects them into the router with the `si/ri` handshake.
- It stamps the VC bit from the router's polarity at injection.
- It accepts ejected flits from the router into a receive FIFO that the PE reads.

## Interface
Parameters:
- `DATA_W`, 64, flit width; bit `DATA_W-1` is the VC bit.
- `DEPTH`, 2, entries per FIFO; power of two, ≥2.
- `CNT_W`, 8, width of the occupancy field in status words.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low.
- `addr`  in  2  PE register address.
- `d_in`  in  `DATA_W`  PE write data.
- `d_out`  out  `DATA_W`  PE read data (combinational).
- `nicEn`  in  1  PE access enable.
- `nicWrEn`  in  1  1 = write, 0 = read (qualified by `nicEn`).
- `net_si`  in  1  router has an ejected flit.
- `net_ro`  out  1  NIC can accept an ejected flit.
- `net_di`  in  `DATA_W`  ejected flit.
- `net_so`  out  1  NIC injects a flit.
- `net_ri`  in  1  router can accept an injection.
- `net_do`  out  `DATA_W`  injected flit.
- `net_polarity`  in  1  router VC polarity.

## Operation
Address map:
- 00 read: pop the receive (RX) FIFO.
- 01 read: RX status.
- 10 write: push the transmit (TX) FIFO.
- 11 read: TX status.
- Accesses not in this list (write to 00/01/11, read of 10) have no effect; `d_out` = 0.

Status words:
- RX status: `[0]` = RX nonempty, `[8 +: CNT_W]` = RX occupancy.
- TX status: `[0]` = TX full, `[8 +: CNT_W]` = TX occupancy.
- All other status bits are 0.

RX path:
- `net_ro` = !rx_full (registered state).
- On a posedge with `net_si & net_ro`, `net_di` is pushed.
- `net_si` while `net_ro`=0 is ignored; the router must hold the flit.

RX read:
- `nicEn & !nicWrEn & addr==00` drives `d_out` = RX head.
- The pop occurs at that posedge.
- Read when empty: `d_out` = 0, no pop, pointers unchanged.

TX write:
- `nicEn & nicWrEn & addr==10` pushes `d_in` at the posedge.
- Write when TX is full is dropped silently. This holds even if a send occurs in the same cycle, so software must poll TX status first.

TX send:
- `net_so` = tx_nonempty & net_ri.
- `net_do` = {net_polarity, tx_head[DATA_W-2:0]}.
- TX pops at a posedge with `net_so`=1.
- When TX is empty, `net_do` = 0.

FIFO pointers:
- `log2(DEPTH)+1` bits; wrap modulo 2·DEPTH.
- Full = low bits equal and MSB different; empty = pointers equal.
- Push and pop in the same cycle on a nonempty, non-full FIFO leave occupancy unchanged.
- RX push and pop in the same cycle while full cannot occur (push is blocked by `net_ro`).

## Timing
- Reset (async assert, sync-safe deassert): pointers = 0, both FIFOs empty.
- Outputs during reset: `net_ro`=1, `net_so`=0, `net_do`=0, `d_out`=0.
- Reset mid-operation discards all buffered flits. An injection in progress that cycle is not completed.
- RX: a flit pushed at edge N is readable on `d_out` (addr 00) in cycle N+1. `net_ro` falls in cycle N+1 if that push filled the FIFO.
- TX: a flit written at edge N gives `net_so` in cycle N+1 if `net_ri`=1.
- Injection throughput is 1 flit/cycle while `net_ri` is held high.
- VC stamp is sampled combinationally in the send cycle, not at write time.
- Status reads reflect state as of the last edge; same-cycle push/pop is not visible until the next cycle.

## Structure
- Package `cardinal_nic_pkg`:
  - address constants `ADDR_RX_DATA`=2'b00, `ADDR_RX_STAT`=2'b01, `ADDR_TX_DATA`=2'b10, `ADDR_TX_STAT`=2'b11;
  - `VC_BIT` position;
  - status bit positions;
  - header field offsets (Dx 62, Dy 61, Hx 55:52, Hy 51:48, SrcX 47:40, SrcY 39:32).
- Sub-module `nic_fifo` (params `DATA_W`, `DEPTH`): push, pop, head, full, empty, count. Instantiated twice (RX, TX).
- Top level holds only the address decode, `d_out` mux, handshake glue and VC stamp.

## Test plan
- Reset low mid-stream with 2 TX flits queued → after release, `net_so`=0, TX status reads 0x0, `net_ro`=1.
- Write 0x0000_0000_0000_00A5 to addr 10 with `net_ri`=1 and `net_polarity`=1 → next cycle `net_so`=1, `net_do`=0x8000_0000_0000_00A5; TX empties.
- `net_ri`=0, write 3 flits (DEPTH=2) → TX status = 0x201 (count 2, full); third flit absent after `net_ri`=1. Exactly 2 `net_so` cycles follow, in order.
- Router pushes 2 flits with `net_si` held → `net_ro`=0 after the second. RX status = 0x201; two reads of addr 00 return both flits in order; `net_ro` returns to 1.
- Read addr 00 with RX empty → `d_out`=0, RX status stays 0x0. Then 5 push/pop pairs cycle the pointers across the wrap with data preserved.
- Concurrent traffic: RX push and PE pop in the same cycle at count 1 → count stays 1, data FIFO-ordered. TX send and PE write in the same cycle at count 1 → count stays 1.

Source files
------------

// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal_nic: PE register map, status word layout
// and the flit header fields used by the gold_mesh router.
package cardinal_nic_pkg;

    localparam logic [1:0] ADDR_RX_DATA = 2'b00;
    localparam logic [1:0] ADDR_RX_STAT = 2'b01;
    localparam logic [1:0] ADDR_TX_DATA = 2'b10;
    localparam logic [1:0] ADDR_TX_STAT = 2'b11;

    // VC bit is the flit MSB for the default 64-bit flit.
    localparam int unsigned VC_BIT = 63;

    // Status words: flag in bit 0 (RX nonempty / TX full), occupancy from bit 8.
    localparam int unsigned STAT_FLAG_BIT = 0;
    localparam int unsigned STAT_CNT_LSB  = 8;

    localparam int unsigned HDR_DX       = 62;
    localparam int unsigned HDR_DY       = 61;
    localparam int unsigned HDR_HX_LSB   = 52;
    localparam int unsigned HDR_HX_W     = 4;
    localparam int unsigned HDR_HY_LSB   = 48;
    localparam int unsigned HDR_HY_W     = 4;
    localparam int unsigned HDR_SRCX_LSB = 40;
    localparam int unsigned HDR_SRCX_W   = 8;
    localparam int unsigned HDR_SRCY_LSB = 32;
    localparam int unsigned HDR_SRCY_W   = 8;

endpackage

// File: rtl/nic_fifo.sv
// Flit FIFO with wrap-bit pointers; pushes when full and pops when empty are
// ignored, so callers may present raw requests.
module nic_fifo #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  occupancy;
    logic              do_push;
    logic              do_pop;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                       (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign occupancy = wr_ptr_q - rd_ptr_q;
    assign count     = CNT_W'(occupancy);
    assign head      = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/cardinal_nic.sv
// NIC between a PE and one local router port: register-mapped TX/RX FIFOs,
// si/ri handshake glue and VC stamping at injection.
module cardinal_nic
    import cardinal_nic_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] d_in,
    output logic [DATA_W-1:0] d_out,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic              net_si,
    output logic              net_ro,
    input  logic [DATA_W-1:0] net_di,
    output logic              net_so,
    input  logic              net_ri,
    output logic [DATA_W-1:0] net_do,
    input  logic              net_polarity
);

    logic [DATA_W-1:0] rx_head, tx_head;
    logic              rx_full, rx_empty, tx_full, tx_empty;
    logic [CNT_W-1:0]  rx_count, tx_count;
    logic [DATA_W-1:0] rx_stat, tx_stat;
    logic              pe_read, rx_pop, tx_push;

    assign pe_read = nicEn && !nicWrEn;
    assign rx_pop  = pe_read && (addr == ADDR_RX_DATA);
    assign tx_push = nicEn && nicWrEn && (addr == ADDR_TX_DATA);

    assign net_ro = !rx_full;
    assign net_so = !tx_empty && net_ri;
    // Polarity is taken live in the send cycle, not captured at write time.
    assign net_do = tx_empty ? '0 : {net_polarity, tx_head[DATA_W-2:0]};

    nic_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (net_si),
        .wdata (net_di),
        .pop   (rx_pop),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    nic_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .wdata (d_in),
        .pop   (net_ri),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    always_comb begin
        rx_stat = '0;
        rx_stat[STAT_FLAG_BIT] = !rx_empty;
        rx_stat[STAT_CNT_LSB +: CNT_W] = rx_count;
        tx_stat = '0;
        tx_stat[STAT_FLAG_BIT] = tx_full;
        tx_stat[STAT_CNT_LSB +: CNT_W] = tx_count;
    end

    always_comb begin
        d_out = '0;
        if (pe_read) begin
            case (addr)
                ADDR_RX_DATA: d_out = rx_empty ? '0 : rx_head;
                ADDR_RX_STAT: d_out = rx_stat;
                ADDR_TX_STAT: d_out = tx_stat;
                default:      d_out = '0;
            endcase
        end
    end

endmodule
